// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after last_id, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               any,
    output logic [ID_W-1:0]    pick_id
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after last_id wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path without one infers a latch.
        any     = 1'b0;
        pick_id = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (req[cand]) begin
                any     = 1'b1;
                pick_id = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the async FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH_D   = 8,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = clog2_min1(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                       w_clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         src_valid,
    input  logic [NUM_REQ*WIDTH_D-1:0] src_data,
    output logic [NUM_REQ-1:0]         src_ready,
    input  logic                       w_full,
    output logic                       w_req,
    output logic [WIDTH_D-1:0]         w_data,
    output logic                       grant_vld,
    output logic [ID_W-1:0]            grant_id
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic            pick_any;
    logic [ID_W-1:0] pick_id;
    logic            in_grant;
    logic            cur_valid;
    logic            xfer;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (src_valid),
        .last_id (last_id_q),
        .any     (pick_any),
        .pick_id (pick_id)
    );

    assign in_grant  = (state_q == GRANT);
    assign cur_valid = src_valid[grant_id_q];
    // Gating on w_full here is what keeps the FIFO from ever seeing a write while full.
    assign xfer      = in_grant & cur_valid & ~w_full;

    assign w_req     = xfer;
    assign grant_vld = in_grant;
    assign grant_id  = grant_id_q;

    always_comb begin
        src_ready = '0;
        w_data    = '0;
        if (in_grant) begin
            src_ready[grant_id_q] = ~w_full;
            w_data = src_data[int'(grant_id_q)*WIDTH_D +: WIDTH_D];
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // A dropped valid releases the port; a full stall simply holds everything.
                if (!cur_valid) begin
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer model, expected-beat scoreboard, negedge monitor.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH_D   = 8;
    localparam int MAX_BURST = 16;
    localparam int DEPTH     = 128;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic                       w_clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         src_valid;
    logic [NUM_REQ*WIDTH_D-1:0] src_data;
    logic [NUM_REQ-1:0]         src_ready;
    logic                       w_full;
    logic                       w_req;
    logic [WIDTH_D-1:0]         w_data;
    logic                       grant_vld;
    logic [1:0]                 grant_id;

    always #5 w_clk = ~w_clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH_D   (WIDTH_D),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .w_clk     (w_clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .w_full    (w_full),
        .w_req     (w_req),
        .w_data    (w_data),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    logic [7:0] mem [NUM_REQ][DEPTH];
    int         wr_ptr [NUM_REQ];
    int         rd_ptr [NUM_REQ];
    beat_t      exp_q [$];
    beat_t      mon_e;
    int         n_vec = 0;
    int         n_err = 0;

    logic       obs_w_req, obs_grant_vld;
    logic [1:0] obs_grant_id;
    logic [3:0] obs_src_ready;
    logic [7:0] obs_w_data;
    int         wait_cnt [NUM_REQ];
    int         max_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int id, input logic [7:0] data);
        mem[id][wr_ptr[id]] = data;
        wr_ptr[id]++;
    endtask

    task automatic expect_beat(input int id, input logic [7:0] data);
        exp_q.push_back('{id: 2'(id), data: data});
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_valid[i] = (rd_ptr[i] < wr_ptr[i]);
            src_data[i*WIDTH_D +: WIDTH_D] = (rd_ptr[i] < wr_ptr[i]) ? mem[i][rd_ptr[i]] : 8'h00;
        end
    endtask

    // Observe one cycle at the falling edge, then advance past the next rising edge.
    task automatic step();
        logic [NUM_REQ-1:0] fire;
        @(negedge w_clk);
        fire          = src_valid & src_ready;
        obs_w_req     = w_req;
        obs_grant_vld = grant_vld;
        obs_grant_id  = grant_id;
        obs_src_ready = src_ready;
        obs_w_data    = w_data;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_valid[i] && !(grant_vld && grant_id == 2'(i))) begin
                wait_cnt[i]++;
            end else begin
                // The IDLE cycle that picks a requester is its own arbitration latency, not waiting.
                if (grant_vld && grant_id == 2'(i) && wait_cnt[i] > 0 && wait_cnt[i] - 1 > max_wait)
                    max_wait = wait_cnt[i] - 1;
                wait_cnt[i] = 0;
            end
        end
        @(posedge w_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (fire[i]) rd_ptr[i]++;
        drive();
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic count_beats(input int target, inout int beats, input int max_cyc);
        int n = 0;
        while (beats < target && n < max_cyc) begin
            step();
            n++;
            if (obs_w_req) beats++;
        end
    endtask

    always @(negedge w_clk) begin
        if (w_req === 1'b1) begin
            check("no_write_when_full", w_full, 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got id %0d data 0x%02h, expected no beat", grant_id, w_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_id", grant_id, mon_e.id);
                check("beat_data", w_data, mon_e.data);
            end
        end
    end

    initial begin
        int beats, lows, first_run;
        rst    = 1'b1;
        w_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i]   = 0;
            rd_ptr[i]   = 0;
            wait_cnt[i] = 0;
        end
        max_wait = 0;

        // Reset with every producer valid: outputs stay quiet, then id 0 is served first.
        for (int i = 0; i < NUM_REQ; i++) begin
            load(i, 8'hA0 + 8'(i));
            expect_beat(i, 8'hA0 + 8'(i));
        end
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_w_req", obs_w_req, 0);
            check("rst_src_ready", obs_src_ready, 0);
            check("rst_grant_vld", obs_grant_vld, 0);
            check("rst_w_data", obs_w_data, 0);
        end
        rst = 1'b0;
        step();
        check("post_rst_idle_w_req", obs_w_req, 0);
        check("post_rst_idle_grant", obs_grant_vld, 0);
        step();
        check("first_grant_vld", obs_grant_vld, 1);
        check("first_grant_id", obs_grant_id, 0);
        check("first_w_req", obs_w_req, 1);
        drain("rst_drain", 40);
        step();
        step();

        // Single producer, 40 beats: bursts of 16, 16, 8 separated by one bubble each.
        for (int k = 1; k <= 40; k++) begin
            load(2, 8'(k));
            expect_beat(2, 8'(k));
        end
        drive();
        beats = 0;
        lows = 0;
        first_run = 0;
        for (int n = 0; n < 200 && beats < 40; n++) begin
            step();
            if (obs_w_req) beats++;
            else if (beats > 0) lows++;
            if (lows == 0) first_run = beats;
        end
        check("single_beats", beats, 40);
        check("single_bubbles", lows, 2);
        check("single_first_burst", first_run, 16);
        drain("single_drain", 10);
        step();
        step();

        // Fairness: four always-valid producers, two full rounds of 16-beat grants.
        rst_pulse();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                for (int k = 0; k < 16; k++) begin
                    load(i, {4'(i), 4'(k)});
                    expect_beat(i, {4'(i), 4'(k)});
                end
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
        max_wait = 0;
        drive();
        drain("fair_drain", 300);
        n_vec++;
        if (max_wait > 51) begin
            n_err++;
            $display("FAIL fair_max_wait: got %0d cycles, required at most 51", max_wait);
        end
        step();
        step();

        // Full stall of 7 cycles after beat 5 of id 1's burst.
        rst_pulse();
        for (int k = 0; k < 20; k++) begin
            load(1, 8'hB0 + 8'(k));
            expect_beat(1, 8'hB0 + 8'(k));
        end
        drive();
        beats = 0;
        count_beats(5, beats, 50);
        check("stall_pre_beats", beats, 5);
        w_full = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            check("stall_w_req", obs_w_req, 0);
            check("stall_src_ready", obs_src_ready, 0);
            check("stall_grant_vld", obs_grant_vld, 1);
            check("stall_grant_id", obs_grant_id, 1);
        end
        w_full = 1'b0;
        step();
        check("stall_resume", obs_w_req, 1);
        if (obs_w_req) beats++;
        count_beats(16, beats, 50);
        check("stall_burst_beats", beats, 16);
        step();
        check("stall_end_bubble", obs_grant_vld, 0);
        drain("stall_drain", 30);
        step();
        step();

        // Early release: id 2 drops valid after 3 beats, re-asserts, yet id 3 goes first.
        rst_pulse();
        for (int k = 0; k < 3; k++) begin
            load(2, 8'h21 + 8'(k));
            expect_beat(2, 8'h21 + 8'(k));
        end
        for (int k = 0; k < 4; k++) begin
            load(3, 8'h31 + 8'(k));
            expect_beat(3, 8'h31 + 8'(k));
        end
        expect_beat(2, 8'h24);
        expect_beat(2, 8'h25);
        drive();
        beats = 0;
        count_beats(3, beats, 30);
        check("early_beats", beats, 3);
        step();
        check("early_release_grant", obs_grant_vld, 1);
        check("early_release_id", obs_grant_id, 2);
        check("early_release_w_req", obs_w_req, 0);
        load(2, 8'h24);
        load(2, 8'h25);
        drive();
        step();
        check("early_bubble", obs_grant_vld, 0);
        step();
        check("early_next_vld", obs_grant_vld, 1);
        check("early_next_id", obs_grant_id, 3);
        drain("early_drain", 40);
        step();
        step();

        // Reset during beat 8 of id 0: that beat lands, then arbitration restarts from id 0.
        rst_pulse();
        for (int k = 0; k < 20; k++) begin
            load(0, 8'h40 + 8'(k));
            expect_beat(0, 8'h40 + 8'(k));
        end
        drive();
        beats = 0;
        count_beats(7, beats, 30);
        check("mid_rst_pre_beats", beats, 7);
        rst = 1'b1;
        step();
        check("mid_rst_beat8", obs_w_req, 1);
        rst = 1'b0;
        exp_q.delete();
        for (int k = 8; k < 20; k++) expect_beat(0, 8'h40 + 8'(k));
        step();
        check("mid_rst_idle_vld", obs_grant_vld, 0);
        check("mid_rst_idle_w_req", obs_w_req, 0);
        check("mid_rst_idle_ready", obs_src_ready, 0);
        check("mid_rst_idle_data", obs_w_data, 0);
        step();
        check("mid_rst_regrant_vld", obs_grant_vld, 1);
        check("mid_rst_regrant_id", obs_grant_id, 0);
        check("mid_rst_regrant_w_req", obs_w_req, 1);
        drain("mid_rst_drain", 40);
        step();
        step();
        for (int i = 0; i < NUM_REQ; i++)
            check("final_src_drained", rd_ptr[i], wr_ptr[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the asynchronous FIFO (write side: w_req/w_data/w_full) between NUM_REQ producers in the write clock domain.
- Each producer has a valid/ready handshake. A granted producer holds the port for up to MAX_BURST beats, so FIFO bursts stay contiguous while starvation remains bounded.
- Sits between the producer blocks and the FIFO write port. It runs entirely on w_clk.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH_D, 8, data width; matches the FIFO WIDTH_D.
- MAX_BURST, 16, maximum beats per grant; legal range >=1.

Ports:
- w_clk  input  1  write-domain clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on w_clk rising edge.
- src_valid  input  NUM_REQ  per-requester data-valid.
- src_data  input  NUM_REQ*WIDTH_D  flattened data; requester i occupies bits [i*WIDTH_D +: WIDTH_D].
- src_ready  output  NUM_REQ  per-requester accept; a beat transfers when src_valid[i]&src_ready[i].
- w_full  input  1  FIFO full flag.
- w_req  output  1  FIFO write enable.
- w_data  output  WIDTH_D  FIFO write data.
- grant_vld  output  1  high while the arbiter is in GRANT.
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester; meaningful only when grant_vld=1.

Behaviour:
- States: IDLE, GRANT. Registered: state, grant_id, burst_cnt ($clog2(MAX_BURST)+1 bits), last_id.
- Reset values: state=IDLE, grant_id=0, burst_cnt=0, last_id=NUM_REQ-1, so requester 0 has first priority. With these, all outputs are low/0 after reset: w_req=0, src_ready=0, grant_vld=0, w_data=0.
- IDLE: if any src_valid is high, pick the first valid index scanning last_id+1, last_id+2, ... modulo NUM_REQ. Register it as grant_id, clear burst_cnt, go to GRANT. There is no transfer in IDLE, so request-to-first-beat latency is 1 cycle.
- GRANT, combinational outputs, with g=grant_id:
  - src_ready[g] = ~w_full; all other src_ready bits = 0.
  - w_req = src_valid[g] & ~w_full.
  - w_data = src_data[g]; w_data = 0 when not in GRANT.
- GRANT, transfer cycle (w_req=1): burst_cnt increments. If burst_cnt==MAX_BURST-1, go to IDLE and set last_id=g.
- GRANT, src_valid[g]=0: no transfer; go to IDLE and set last_id=g. Dropping valid ends the grant.
- GRANT, w_full=1 with src_valid[g]=1: stall. Hold state, grant_id and burst_cnt; w_req=0. No timeout.
- Producers must hold src_data stable while src_valid=1 and src_ready=0.
- A requester that re-asserts valid in the same cycle its grant ends is not regranted ahead of other pending requesters.
- Every grant change costs exactly one IDLE bubble cycle.
- Worst-case wait for a continuously-valid requester, excluding full stalls: (NUM_REQ-1)*(MAX_BURST+1) cycles.
- MAX_BURST=1: every beat is followed by re-arbitration, so at most 1 beat per 2 cycles.
- rst asserted in any state: next edge goes to reset values. Any in-flight burst is abandoned; beats already written stay in the FIFO.
- w_req is never high while w_full is high, so the FIFO never sees an overflow attempt.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum arb_state_e {IDLE, GRANT};
  - function clog2_min1 (width helper, returns >=1).
- Sub-module rr_pick: purely combinational, parameter NUM_REQ.
  - Inputs: req[NUM_REQ], last_id.
  - Outputs: any, pick_id.
  - Instantiated once in the IDLE path.
- fifo_wr_arbiter holds the FSM, counters and output mux.

Test Plan:
- Reset: rst=1 for 3 cycles with all src_valid=1 -> w_req=0, src_ready=0, grant_vld=0 throughout. First grant after release goes to id 0; first w_req is 2 cycles after rst falls.
- Single requester: src_valid=4'b0100, 40 incrementing bytes 0x01..0x28, w_full=0.
  - Beats come in bursts of 16, each followed by one bubble.
  - FIFO receives 0x01..0x28 in order, with w_req low on exactly 2 cycles between beats.
- Fairness: all four requesters continuously valid with tagged data (upper nibble = id).
  - Grant order 0,1,2,3,0... with exactly 16 beats per grant.
  - Check that 3*(16+1)=51 cycles is not exceeded for any requester.
- Full stall: grant id 1 mid-burst at beat 5, w_full=1 for 7 cycles.
  - w_req=0 and src_ready=0 for those 7 cycles; grant_id stays 1.
  - Burst resumes at beat 6 and ends after beat 16, with no duplicated or lost data.
- Early release: id 2 drops valid after 3 beats while id 3 is pending -> 1 IDLE cycle, then grant_id=3. Id 2 re-asserts immediately but is served only after id 3's grant ends.
- Mid-burst reset: rst=1 during the beat-8 cycle of grant id 0 -> next cycle is IDLE with all outputs 0, then arbitration restarts from id 0. The bench scoreboard flushes its expected stream at reset.
